// File: rtl/song_sequencer_if.sv
// Bundle between the song sequencer, the song ROM, the MCU controls and the note player.
interface song_sequencer_if #(
   parameter int unsigned SONG_BITS  = 2,
   parameter int unsigned INDEX_BITS = 5
);
   logic                            play;
   logic [SONG_BITS-1:0]            song;
   logic [SONG_BITS+INDEX_BITS-1:0] rom_addr;
   logic [11:0]                     rom_data;
   logic                            note_done;
   logic [5:0]                      note_to_load;
   logic [5:0]                      duration_to_load;
   logic                            load_new_note;
   logic                            song_done;

   // Environment side: MCU controls, ROM data and player done flag.
   modport master (
      output play, song, rom_data, note_done,
      input  rom_addr, note_to_load, duration_to_load, load_new_note, song_done
   );

   // Sequencer side.
   modport slave (
      input  play, song, rom_data, note_done,
      output rom_addr, note_to_load, duration_to_load, load_new_note, song_done
   );
endinterface

// File: rtl/song_sequencer.sv
// Song sequencer: walks the song ROM one note/duration entry at a time, hands each note to
// the note player with a one-cycle load strobe and waits for its done flag before moving on.
module song_sequencer #(
   parameter int unsigned SONG_BITS  = 2,
   parameter int unsigned INDEX_BITS = 5
) (
   input logic                clk,
   input logic                reset,
   song_sequencer_if.slave    bus
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StLatch,
      StIssue,
      StGuard,
      StWait,
      StEnd
   } state_e;

   localparam logic [INDEX_BITS-1:0] LastIdx = {INDEX_BITS{1'b1}};

   state_e                  state_q;
   logic [INDEX_BITS-1:0]   idx_q;
   logic [SONG_BITS-1:0]    cur_song_q;
   logic [5:0]              note_q;
   logic [5:0]              dur_q;
   logic                    load_q;
   logic                    done_q;

   // Sequencer FSM; strobes are registered and set on the transition into ISSUE/END.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         cur_song_q <= '0;
         note_q     <= '0;
         dur_q      <= '0;
         load_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         load_q <= 1'b0;
         done_q <= 1'b0;
         // A new song selection overrides everything, including a pending END.
         if (bus.song != cur_song_q) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cur_song_q <= bus.song;
         end else begin
            case (state_q)
               StIdle: begin
                  if (bus.play) state_q <= StFetch;
               end
               StFetch: begin
                  state_q <= StLatch;
               end
               StLatch: begin
                  note_q <= bus.rom_data[11:6];
                  dur_q  <= bus.rom_data[5:0];
                  // Zero duration marks the end of a short song; that entry is never played.
                  if (bus.rom_data[5:0] == 6'd0) begin
                     state_q <= StEnd;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StIssue;
                     load_q  <= 1'b1;
                  end
               end
               StIssue: begin
                  state_q <= StGuard;
               end
               StGuard: begin
                  // The previous note's done flag is still up here; skip it.
                  state_q <= StWait;
               end
               StWait: begin
                  if (bus.note_done && bus.play) begin
                     if (idx_q == LastIdx) begin
                        state_q <= StEnd;
                        done_q  <= 1'b1;
                     end else begin
                        idx_q   <= idx_q + 1'b1;
                        state_q <= StFetch;
                     end
                  end
               end
               StEnd: begin
                  idx_q   <= '0;
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign bus.rom_addr         = {cur_song_q, idx_q};
   assign bus.note_to_load     = note_q;
   assign bus.duration_to_load = dur_q;
   assign bus.load_new_note    = load_q;
   assign bus.song_done        = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: ROM and note-player models, a load scoreboard,
// a table of single-note vectors and hand-written multi-cycle sequences.
module tb_song_sequencer;

   localparam int unsigned SB = 2;
   localparam int unsigned IB = 5;

   logic clk;
   logic reset;

   song_sequencer_if #(.SONG_BITS(SB), .INDEX_BITS(IB)) bus ();

   song_sequencer #(.SONG_BITS(SB), .INDEX_BITS(IB)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous song ROM.
   logic [11:0] rom [0:127];
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   // Note player: done rises 3 beats after each load and stays up until the next load.
   logic player_en;
   int   player_cnt;
   always @(posedge clk) begin
      if (!player_en) begin
         player_cnt    <= 0;
         bus.note_done <= 1'b0;
      end else if (bus.load_new_note) begin
         player_cnt    <= 3;
         bus.note_done <= 1'b0;
      end else if (player_cnt != 0) begin
         player_cnt    <= player_cnt - 1;
         bus.note_done <= (player_cnt == 1);
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   int load_cnt = 0;
   int done_cnt = 0;

   typedef logic [18:0] rec_t;   // {rom_addr, note, duration}
   rec_t exp_q[$];
   rec_t mon_e;
   rec_t mon_a;
   logic prev_load = 1'b0;
   logic prev_done = 1'b0;

   // Scoreboard and strobe-shape monitor.
   always @(negedge clk) begin
      if (!reset && (bus.load_new_note || bus.song_done)) begin
         n_cmp++;
         if ((bus.load_new_note && bus.song_done) || (bus.load_new_note && prev_load) ||
             (bus.song_done && prev_done)) begin
            n_fail++;
            $display("FAIL strobe_shape: load=%0b done=%0b prev_load=%0b prev_done=%0b, required exclusive single-cycle strobes",
                     bus.load_new_note, bus.song_done, prev_load, prev_done);
         end
      end
      if (bus.load_new_note) begin
         load_cnt++;
         n_cmp++;
         mon_a = {bus.rom_addr, bus.note_to_load, bus.duration_to_load};
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_load: got load at addr=%0d, required no load", bus.rom_addr);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_a != mon_e) begin
               n_fail++;
               $display("FAIL load_record: got addr=%0d note=%0d dur=%0d, required addr=%0d note=%0d dur=%0d",
                        mon_a[18:12], mon_a[11:6], mon_a[5:0], mon_e[18:12], mon_e[11:6], mon_e[5:0]);
            end
         end
      end
      if (bus.song_done) done_cnt++;
      prev_load <= bus.load_new_note;
      prev_done <= bus.song_done;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Reset, then let a song change (if any) settle so the sequencer idles on song s.
   task automatic do_reset(input logic [1:0] s);
      reset     = 1'b1;
      bus.play  = 1'b0;
      bus.song  = s;
      player_en = 1'b0;
      ticks(2);
      reset = 1'b0;
      ticks(2);
      exp_q.delete();
      load_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic wait_load(input int max, output int cyc);
      bit ok = 1'b0;
      cyc = 0;
      while (cyc < max && !ok) begin
         tick();
         cyc++;
         if (bus.load_new_note) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_load: no load within %0d cycles, required a load", max);
      end
   endtask

   task automatic wait_done(input int max);
      bit ok = 1'b0;
      int cyc = 0;
      while (cyc < max && !ok) begin
         tick();
         cyc++;
         if (bus.song_done) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_done: no song_done within %0d cycles, required a pulse", max);
      end
   endtask

   typedef struct {
      logic [1:0] song;
      logic [5:0] note;
      logic [5:0] dur;
      logic [6:0] exp_addr;
      logic       exp_load;
      logic       exp_done;
   } vec_t;

   vec_t vecs[4];
   int   cyc;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 128; i++) rom[i] = 12'h041;
      reset     = 1'b1;
      bus.play  = 1'b0;
      bus.song  = '0;
      player_en = 1'b0;
      ticks(2);

      // Reset values.
      check("reset_load", bus.load_new_note, 0);
      check("reset_done", bus.song_done, 0);
      check("reset_addr", bus.rom_addr, 0);
      check("reset_note", bus.note_to_load, 0);
      check("reset_dur", bus.duration_to_load, 0);

      // Single-note vectors: play sampled at cycle 0 -> FETCH 1, LATCH 2, strobe 3.
      vecs[0] = '{2'd1, 6'd10, 6'd3, 7'd32, 1'b1, 1'b0};
      vecs[1] = '{2'd0, 6'd63, 6'd63, 7'd0, 1'b1, 1'b0};
      vecs[2] = '{2'd3, 6'd1, 6'd1, 7'd96, 1'b1, 1'b0};
      vecs[3] = '{2'd2, 6'd5, 6'd0, 7'd64, 1'b0, 1'b1};
      for (int v = 0; v < 4; v++) begin
         rom[vecs[v].exp_addr] = {vecs[v].note, vecs[v].dur};
         do_reset(vecs[v].song);
         if (vecs[v].exp_load) exp_q.push_back({vecs[v].exp_addr, vecs[v].note, vecs[v].dur});
         bus.play = 1'b1;
         tick();
         check("vec_fetch_addr", bus.rom_addr, vecs[v].exp_addr);
         check("vec_fetch_load", bus.load_new_note, 0);
         tick();
         check("vec_latch_load", bus.load_new_note, 0);
         tick();
         check("vec_strobe_load", bus.load_new_note, vecs[v].exp_load);
         check("vec_strobe_done", bus.song_done, vecs[v].exp_done);
         check("vec_note", bus.note_to_load, vecs[v].note);
         check("vec_dur", bus.duration_to_load, vecs[v].dur);
         // Loaded note: play stays high, done stays low, so the sequencer must sit in WAIT.
         bus.play = vecs[v].exp_load;
         ticks(10);
         check("vec_load_count", load_cnt, vecs[v].exp_load);
         check("vec_done_count", done_cnt, vecs[v].exp_done);
         check("vec_queue_empty", exp_q.size(), 0);
      end

      // Full 32-note song 0.
      for (int i = 0; i < 32; i++) rom[i] = {6'(i + 1), 6'd2};
      do_reset(2'd0);
      for (int i = 0; i < 32; i++) exp_q.push_back({7'(i), 6'(i + 1), 6'd2});
      player_en = 1'b1;
      bus.play  = 1'b1;
      wait_done(2000);
      bus.play = 1'b0;
      check("full_end_addr", bus.rom_addr, 31);
      check("full_load_count", load_cnt, 32);
      check("full_queue_empty", exp_q.size(), 0);
      ticks(4);
      check("full_idle_addr", bus.rom_addr, 0);
      check("full_done_count", done_cnt, 1);
      check("full_no_extra_load", load_cnt, 32);

      // Song 2 terminated by a zero-duration entry at index 3.
      for (int i = 0; i < 3; i++) rom[64 + i] = {6'(20 + i), 6'd5};
      rom[67] = {6'd9, 6'd0};
      do_reset(2'd2);
      for (int i = 0; i < 3; i++) exp_q.push_back({7'(64 + i), 6'(20 + i), 6'd5});
      player_en = 1'b1;
      bus.play  = 1'b1;
      wait_done(500);
      bus.play = 1'b0;
      check("term_addr", bus.rom_addr, 67);
      check("term_note", bus.note_to_load, 9);
      check("term_dur", bus.duration_to_load, 0);
      check("term_load_count", load_cnt, 3);
      ticks(5);
      check("term_no_extra_load", load_cnt, 3);
      check("term_done_count", done_cnt, 1);
      check("term_queue_empty", exp_q.size(), 0);

      // Pause in WAIT with done high.
      for (int i = 0; i < 4; i++) rom[32 + i] = {6'(30 + i), 6'd1};
      do_reset(2'd1);
      exp_q.push_back({7'd32, 6'd30, 6'd1});
      player_en = 1'b1;
      bus.play  = 1'b1;
      wait_load(20, cyc);
      bus.play = 1'b0;
      ticks(20);
      check("pause_note_done", bus.note_done, 1);
      check("pause_load_count", load_cnt, 1);
      check("pause_addr", bus.rom_addr, 32);
      exp_q.push_back({7'd33, 6'd31, 6'd1});
      bus.play = 1'b1;
      wait_load(20, cyc);
      bus.play = 1'b0;
      // Edges: WAIT->FETCH, FETCH->LATCH, LATCH->ISSUE.
      check("pause_resume_latency", cyc, 3);
      ticks(3);
      check("pause_load_count2", load_cnt, 2);
      check("pause_queue_empty", exp_q.size(), 0);

      // Song change 0 -> 3 while waiting at index 7.
      for (int i = 0; i < 8; i++) rom[i] = {6'(40 + i), 6'd1};
      rom[96] = {6'd50, 6'd7};
      do_reset(2'd0);
      for (int i = 0; i < 8; i++) exp_q.push_back({7'(i), 6'(40 + i), 6'd1});
      player_en = 1'b1;
      bus.play  = 1'b1;
      for (int k = 0; k < 8; k++) wait_load(40, cyc);
      player_en = 1'b0;
      ticks(5);
      check("chg_wait_addr", bus.rom_addr, 7);
      bus.song = 2'd3;
      exp_q.push_back({7'd96, 6'd50, 6'd7});
      tick();
      check("chg_no_done", bus.song_done, 0);
      check("chg_no_load", bus.load_new_note, 0);
      check("chg_addr", bus.rom_addr, 96);
      wait_load(10, cyc);
      bus.play = 1'b0;
      check("chg_restart_latency", cyc, 3);
      ticks(3);
      check("chg_queue_empty", exp_q.size(), 0);
      check("chg_done_count", done_cnt, 0);

      // Reset asserted during ISSUE.
      rom[0] = {6'd12, 6'd4};
      do_reset(2'd0);
      exp_q.push_back({7'd0, 6'd12, 6'd4});
      bus.play = 1'b1;
      wait_load(10, cyc);
      reset = 1'b1;
      tick();
      check("rst_load", bus.load_new_note, 0);
      check("rst_done", bus.song_done, 0);
      check("rst_note", bus.note_to_load, 0);
      check("rst_dur", bus.duration_to_load, 0);
      check("rst_addr", bus.rom_addr, 0);
      reset = 1'b0;
      exp_q.push_back({7'd0, 6'd12, 6'd4});
      wait_load(10, cyc);
      bus.play = 1'b0;
      check("rst_restart_latency", cyc, 3);
      ticks(3);
      check("rst_queue_empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
